// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   pctl_state_t : controller FSM state (RUN / MD_BUSY)
//   ctrl_t       : per-cycle PC and stage-register enable/flush bundle
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } pctl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
    logic mem_wb_flush;
  } ctrl_t;

  // Free-running pipeline: every stage advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN   = ctrl_t'(9'b1_10_10_10_10);
  // Reset: squash every stage register and freeze the PC.
  localparam ctrl_t CTRL_RST   = ctrl_t'(9'b0_01_01_01_01);
  // Memory wait: freeze everything up to EX/MEM, bubble into MEM/WB.
  localparam ctrl_t CTRL_DMEM  = ctrl_t'(9'b0_00_00_00_11);
  // Mul/div in flight: freeze front end, bubble into EX/MEM, let MEM/WB drain.
  localparam ctrl_t CTRL_MDH   = ctrl_t'(9'b0_00_00_01_10);
  // Taken branch/jump: load target, squash the two wrong-path instructions.
  localparam ctrl_t CTRL_REDIR = ctrl_t'(9'b1_11_11_10_10);
  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam ctrl_t CTRL_LU    = ctrl_t'(9'b0_00_11_10_10);

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detection.
//   inputs : ID source indices and use flags, EX destination and load flag
//   outputs: load_use_c - ID instruction needs the result of the load in EX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use_c = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage RV32IM pipeline.
//   inputs : ID/EX hazard info, redirect, mul/div done, data-memory wait
//   outputs: PC enable, en/flush per pipeline register (combinational),
//            md_start pulse (combinational), md_timeout (sticky, registered),
//            stall_cycles performance counter (registered)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_MAX_CYCLES = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_md,
  input  logic             ex_redirect,
  input  logic             md_done,
  input  logic             dmem_stall,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned     WD_W    = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

  pctl_state_t     state, state_nxt;
  logic            md_done_seen, md_done_seen_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            wd_expire_c;
  logic            md_release_c;
  logic            timeout_set_c;
  logic            load_use_c;
  ctrl_t           ctrl_c;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use_c  (load_use_c)
  );

  assign wd_expire_c  = (wd_cnt == WD_LAST);
  assign md_release_c = md_done || md_done_seen || wd_expire_c;

  // Next-state and stage-control decode, highest priority first.
  always_comb begin
    ctrl_c           = CTRL_RUN;
    md_start         = 1'b0;
    state_nxt        = state;
    md_done_seen_nxt = md_done_seen;
    wd_cnt_nxt       = wd_cnt;
    timeout_set_c    = 1'b0;

    if (rst) begin
      ctrl_c = CTRL_RST;
    end else if (dmem_stall) begin
      ctrl_c = CTRL_DMEM;
      // Remember a done that lands while MEM is frozen; release afterwards.
      if ((state == MD_BUSY) && md_done) begin
        md_done_seen_nxt = 1'b1;
      end
    end else if (state == MD_BUSY) begin
      if (md_release_c) begin
        ctrl_c           = CTRL_RUN;
        state_nxt        = RUN;
        md_done_seen_nxt = 1'b0;
        wd_cnt_nxt       = '0;
        timeout_set_c    = !md_done && !md_done_seen;
      end else begin
        ctrl_c     = CTRL_MDH;
        wd_cnt_nxt = wd_cnt + WD_W'(1);
      end
    end else if (ex_is_md) begin
      ctrl_c     = CTRL_MDH;
      md_start   = 1'b1;
      state_nxt  = MD_BUSY;
      wd_cnt_nxt = '0;
    end else if (ex_redirect) begin
      // Wrong-path instruction in ID makes any load-use match irrelevant.
      ctrl_c = CTRL_REDIR;
    end else if (load_use_c) begin
      ctrl_c = CTRL_LU;
    end
  end

  // State, watchdog and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      md_done_seen <= 1'b0;
      wd_cnt       <= '0;
      stall_cycles <= '0;
      md_timeout   <= 1'b0;
    end else begin
      state        <= state_nxt;
      md_done_seen <= md_done_seen_nxt;
      wd_cnt       <= wd_cnt_nxt;
      if (!ctrl_c.pc_en) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (timeout_set_c) begin
        md_timeout <= 1'b1;
      end
    end
  end

  assign pc_en        = ctrl_c.pc_en;
  assign if_id_en     = ctrl_c.if_id_en;
  assign if_id_flush  = ctrl_c.if_id_flush;
  assign id_ex_en     = ctrl_c.id_ex_en;
  assign id_ex_flush  = ctrl_c.id_ex_flush;
  assign ex_mem_en    = ctrl_c.ex_mem_en;
  assign ex_mem_flush = ctrl_c.ex_mem_flush;
  assign mem_wb_en    = ctrl_c.mem_wb_en;
  assign mem_wb_flush = ctrl_c.mem_wb_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expectations are queued when
// stimulus is applied and popped/compared once the outputs have settled.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_is_md, ex_redirect;
  logic        md_done, dmem_stall;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
  logic        md_start, md_timeout;
  logic [31:0] stall_cycles;

  pipe_ctrl #(.MD_MAX_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_md(ex_is_md), .ex_redirect(ex_redirect),
    .md_done(md_done), .dmem_stall(dmem_stall),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .md_start(md_start), .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Output vector order: pc_en, if_id en/flush, id_ex en/flush,
  // ex_mem en/flush, mem_wb en/flush, md_start.
  localparam logic [9:0] V_DEF   = 10'b1_10_10_10_10_0;
  localparam logic [9:0] V_RST   = 10'b0_01_01_01_01_0;
  localparam logic [9:0] V_DMEM  = 10'b0_00_00_00_11_0;
  localparam logic [9:0] V_HOLD  = 10'b0_00_00_01_10_0;
  localparam logic [9:0] V_START = 10'b0_00_00_01_10_1;
  localparam logic [9:0] V_REDIR = 10'b1_11_11_10_10_0;
  localparam logic [9:0] V_LU    = 10'b0_00_11_10_10_0;

  localparam int F_RST = 1, F_MR = 2, F_U1 = 4, F_U2 = 8, F_MD = 16;
  localparam int F_RDR = 32, F_DONE = 64, F_DS = 128, F_NOCHK = 256;

  typedef struct packed {
    logic       rst, mr;
    logic [4:0] rd, rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2, md, rdr, done, ds, nochk;
  } stim_t;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic        to;
    logic        chk;
    logic [31:0] stall;
  } exp_t;

  exp_t        sbq[$];
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] exp_stall = 32'd0;

  function automatic stim_t st(int f, int rd, int rs1, int rs2);
    stim_t s;
    s.rst   = (f & F_RST)   != 0;
    s.mr    = (f & F_MR)    != 0;
    s.u1    = (f & F_U1)    != 0;
    s.u2    = (f & F_U2)    != 0;
    s.md    = (f & F_MD)    != 0;
    s.rdr   = (f & F_RDR)   != 0;
    s.done  = (f & F_DONE)  != 0;
    s.ds    = (f & F_DS)    != 0;
    s.nochk = (f & F_NOCHK) != 0;
    s.rd    = rd[4:0];
    s.rs1   = rs1[4:0];
    s.rs2   = rs2[4:0];
    return s;
  endfunction

  function automatic logic [9:0] outs();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
            ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, md_start};
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show for it.
  // e = {md_timeout, control vector}. stall_cycles counts earlier cycles only.
  task automatic apply(input stim_t s, input logic [10:0] e);
    exp_t x;
    @(negedge clk);
    rst = s.rst; ex_mem_read = s.mr; ex_rd = s.rd; id_rs1 = s.rs1; id_use_rs1 = s.u1;
    id_rs2 = s.rs2; id_use_rs2 = s.u2; ex_is_md = s.md; ex_redirect = s.rdr;
    md_done = s.done; dmem_stall = s.ds;
    x.ctrl  = e[9:0];
    x.to    = e[10];
    x.chk   = !s.nochk;
    x.stall = exp_stall;
    sbq.push_back(x);
    if (s.rst) exp_stall = 32'd0;
    else if (!e[9]) exp_stall = exp_stall + 32'd1;
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_RST | F_NOCHK, 0, 0, 0)); e.push_back({1'b0, V_RST});
    s.push_back(st(F_RST, 0, 0, 0));           e.push_back({1'b0, V_RST});
    s.push_back(st(0, 0, 0, 0));               e.push_back({1'b0, V_DEF});
    s.push_back(st(0, 0, 0, 0));               e.push_back({1'b0, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests++;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL reset.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (x.chk) begin
        tests += 2;
        if (stall_cycles !== x.stall) begin failed++; $display("FAIL reset.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
        if (md_timeout !== x.to) begin failed++; $display("FAIL reset.timeout[%0d] got %b want %b", i, md_timeout, x.to); end
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_MR | F_U1, 5, 5, 0));        e.push_back({1'b0, V_LU});
    s.push_back(st(0, 0, 0, 0));                  e.push_back({1'b0, V_DEF});
    s.push_back(st(F_MR | F_U1, 0, 0, 0));        e.push_back({1'b0, V_DEF});
    s.push_back(st(F_MR | F_U2, 7, 3, 7));        e.push_back({1'b0, V_LU});
    s.push_back(st(F_MR, 9, 9, 9));               e.push_back({1'b0, V_DEF});
    s.push_back(st(F_MR | F_U1 | F_U2, 4, 5, 6)); e.push_back({1'b0, V_DEF});
    s.push_back(st(F_U1, 5, 5, 0));               e.push_back({1'b0, V_DEF});
    s.push_back(st(F_DS, 0, 0, 0));               e.push_back({1'b0, V_DMEM});
    s.push_back(st(0, 0, 0, 0));                  e.push_back({1'b0, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests += 3;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL load_use.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (stall_cycles !== x.stall) begin failed++; $display("FAIL load_use.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
      if (md_timeout !== x.to) begin failed++; $display("FAIL load_use.timeout[%0d] got %b want %b", i, md_timeout, x.to); end
    end
  endtask

  task automatic test_redirect();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_RDR | F_MR | F_U1, 5, 5, 0)); e.push_back({1'b0, V_REDIR});
    s.push_back(st(0, 0, 0, 0));                   e.push_back({1'b0, V_DEF});
    s.push_back(st(F_RDR, 0, 0, 0));               e.push_back({1'b0, V_REDIR});
    s.push_back(st(0, 0, 0, 0));                   e.push_back({1'b0, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests += 2;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL redirect.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (stall_cycles !== x.stall) begin failed++; $display("FAIL redirect.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
    end
  endtask

  task automatic test_mul();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b0, V_START});
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(F_MD, 0, 0, 0));        e.push_back({1'b0, V_HOLD});
    end
    s.push_back(st(F_MD | F_DONE, 0, 0, 0)); e.push_back({1'b0, V_DEF});
    s.push_back(st(0, 0, 0, 0));             e.push_back({1'b0, V_DEF});
    s.push_back(st(0, 0, 0, 0));             e.push_back({1'b0, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests += 3;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL mul.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (stall_cycles !== x.stall) begin failed++; $display("FAIL mul.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
      if (md_timeout !== x.to) begin failed++; $display("FAIL mul.timeout[%0d] got %b want %b", i, md_timeout, x.to); end
    end
  endtask

  task automatic test_md_dmem();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_MD | F_DS, 0, 0, 0));          e.push_back({1'b0, V_DMEM});
    s.push_back(st(F_MD, 0, 0, 0));                 e.push_back({1'b0, V_START});
    s.push_back(st(F_MD, 0, 0, 0));                 e.push_back({1'b0, V_HOLD});
    s.push_back(st(F_MD | F_DS, 0, 0, 0));          e.push_back({1'b0, V_DMEM});
    s.push_back(st(F_MD | F_DS | F_DONE, 0, 0, 0)); e.push_back({1'b0, V_DMEM});
    s.push_back(st(F_MD | F_DS, 0, 0, 0));          e.push_back({1'b0, V_DMEM});
    s.push_back(st(F_MD, 0, 0, 0));                 e.push_back({1'b0, V_DEF});
    s.push_back(st(0, 0, 0, 0));                    e.push_back({1'b0, V_DEF});
    s.push_back(st(0, 0, 0, 0));                    e.push_back({1'b0, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests += 3;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL md_dmem.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (stall_cycles !== x.stall) begin failed++; $display("FAIL md_dmem.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
      if (md_timeout !== x.to) begin failed++; $display("FAIL md_dmem.timeout[%0d] got %b want %b", i, md_timeout, x.to); end
    end
  endtask

  task automatic test_watchdog();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b0, V_START});
    for (int k = 0; k < 7; k++) begin
      s.push_back(st(F_MD, 0, 0, 0));        e.push_back({1'b0, V_HOLD});
    end
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b0, V_DEF});
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(0, 0, 0, 0));           e.push_back({1'b1, V_DEF});
    end
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b1, V_START});
    s.push_back(st(F_MD | F_DONE, 0, 0, 0)); e.push_back({1'b1, V_DEF});
    s.push_back(st(0, 0, 0, 0));             e.push_back({1'b1, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests += 3;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL watchdog.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (stall_cycles !== x.stall) begin failed++; $display("FAIL watchdog.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
      if (md_timeout !== x.to) begin failed++; $display("FAIL watchdog.timeout[%0d] got %b want %b", i, md_timeout, x.to); end
    end
  endtask

  task automatic test_reset_mid_busy();
    stim_t s[$]; logic [10:0] e[$];
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b1, V_START});
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b1, V_HOLD});
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b1, V_HOLD});
    s.push_back(st(F_RST | F_MD, 0, 0, 0));  e.push_back({1'b1, V_RST});
    s.push_back(st(F_MD, 0, 0, 0));          e.push_back({1'b0, V_START});
    s.push_back(st(F_MD | F_DONE, 0, 0, 0)); e.push_back({1'b0, V_DEF});
    s.push_back(st(0, 0, 0, 0));             e.push_back({1'b0, V_DEF});
    foreach (s[i]) begin
      exp_t x;
      apply(s[i], e[i]);
      x = sbq.pop_front();
      tests += 3;
      if (outs() !== x.ctrl) begin failed++; $display("FAIL rst_busy.ctrl[%0d] got %b want %b", i, outs(), x.ctrl); end
      if (stall_cycles !== x.stall) begin failed++; $display("FAIL rst_busy.stall[%0d] got %0d want %0d", i, stall_cycles, x.stall); end
      if (md_timeout !== x.to) begin failed++; $display("FAIL rst_busy.timeout[%0d] got %b want %b", i, md_timeout, x.to); end
    end
  endtask

  initial begin
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_is_md = 1'b0;
    ex_redirect = 1'b0; md_done = 1'b0; dmem_stall = 1'b0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mul();
    test_md_dmem();
    test_watchdog();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
